fifo_wr_arbiter: RTL and testbench

- Round-robin write-side arbiter that shares the single 8-deep x 8-bit `fifo` between NUM_REQ producers.
- Grants one producer at a time for a burst of up to BURST_LEN words.
- Drives `fifo.wr` and `fifo.data_in` and returns a per-producer accept strobe.
- Throttles on `fifo.full`; the read side of the FIFO is untouched.

---
 rtl/fifo_arb_pkg.sv | 37 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter: state encoding,
// FIFO geometry constants and the rotating-priority pick function.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 8;

    // Request vector is padded to 8 lanes (the maximum producer count); only
    // the low num_req bits take part. Search starts just after last_idx.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  req,
        input logic [2:0]  last_idx,
        input int unsigned num_req
    );
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            if (k <= num_req && !found) begin
                idx = (int'(last_idx) + k) % num_req;
                if (req[idx[2:0]]) begin
                    win   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request after last_idx,
// wrapping modulo N. Kept separate so a read-side scheduler can reuse it.
module rr_pick_comb
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [7:0] req_pad;
    logic [2:0] last_pad;
    logic [2:0] win_pad;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        last_pad       = '0;
        last_pad[IDX_W-1:0] = last_idx;
    end

    assign win_pad = rr_pick(req_pad, last_pad, N);
    assign winner  = win_pad[IDX_W-1:0];
    assign any     = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO between NUM_REQ producers,
// bursts of up to BURST_LEN words. Optional per-producer counters: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [IDX_W-1:0] last_idx_reg, last_idx_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             in_burst;
    logic             owner_req;
    logic [DATA_W-1:0] lane [NUM_REQ];

    rr_pick_comb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req      (req),
        .last_idx (last_idx_reg),
        .winner   (winner),
        .any      (any_req)
    );

    assign in_burst  = (state_reg == ARB_BURST);
    assign owner_req = req[gnt_idx_reg];
    assign fifo_wr   = !rst && in_burst && owner_req && !fifo_full;
    assign busy      = !rst && in_burst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane[gi] = req_data[gi*DATA_W +: DATA_W];
            assign gnt[gi]  = busy && (gnt_idx_reg == IDX_W'(gi));
            assign ack[gi]  = fifo_wr && (gnt_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Data lane follows the owner index in every state, including IDLE.
    assign fifo_data_in = lane[gnt_idx_reg];

    always_comb begin
        state_next    = state_reg;
        gnt_idx_next  = gnt_idx_reg;
        last_idx_next = last_idx_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (any_req) begin
                    gnt_idx_next  = winner;
                    last_idx_next = winner;
                    beat_cnt_next = '0;
                    state_next    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                // A full stall holds grant and beat count untouched.
                if (!owner_req) begin
                    state_next = ARB_IDLE;
                end else if (fifo_wr) begin
                    if (beat_cnt_reg == CNT_W'(BURST_LEN - 1)) begin
                        state_next = ARB_IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            gnt_idx_reg  <= '0;
            last_idx_reg <= IDX_W'(NUM_REQ - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_idx_reg  <= gnt_idx_next;
            last_idx_reg <= last_idx_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (ack[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a behavioural model predicts grants and
// writes; predicted writes go to a queue that a monitor checks against fifo_wr.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_data_in;
    logic [N-1:0]    ack;
    logic [N-1:0]    gnt;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .ack          (ack),
        .gnt          (gnt),
        .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected writes: producer index in bits [15:8], data word in [7:0].
    int exp_q[$];

    // Model: owner = -1 when nobody holds the FIFO.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_done  = 0;
    int m_words [N];
    int seq     [N];

    logic         e_wr, e_busy;
    logic [N-1:0] e_gnt, e_ack;

    function automatic logic [DW-1:0] word_of(int i, int s);
        return DW'(i * 64 + (s % 64));
    endfunction

    // mode 0: random; 1: all requesting, never full; 2: idle
    task automatic cycle(input bit r, input int mode);
        int w;
        @(posedge clk);
        #1;
        rst = r;
        if (mode == 1) begin
            req       = '1;
            fifo_full = 1'b0;
        end else if (mode == 2) begin
            req       = '0;
            fifo_full = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            fifo_full = ($urandom_range(0, 4) == 0);
        end
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = word_of(i, seq[i]);

        e_wr = 1'b0; e_busy = 1'b0; e_gnt = '0; e_ack = '0;
        if (r) begin
            m_owner = -1;
            m_last  = N - 1;
            m_done  = 0;
            for (int i = 0; i < N; i++) m_words[i] = 0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_done  = 0;
            end
        end else begin
            e_busy = 1'b1;
            e_gnt[m_owner] = 1'b1;
            if (req[m_owner] && !fifo_full) begin
                e_wr = 1'b1;
                e_ack[m_owner] = 1'b1;
                exp_q.push_back(m_owner * 256 + int'(word_of(m_owner, seq[m_owner])));
                seq[m_owner]++;
                m_words[m_owner]++;
                m_done++;
            end
            if (!req[m_owner] || m_done == BL) m_owner = -1;
        end

        @(negedge clk);
        checks++;
        if ({busy, gnt, ack, fifo_wr} !== {e_busy, e_gnt, e_ack, e_wr}) begin
            errors++;
            $display("FAIL ctrl t=%0t busy/gnt/ack/wr got %b/%b/%b/%b want %b/%b/%b/%b",
                     $time, busy, gnt, ack, fifo_wr, e_busy, e_gnt, e_ack, e_wr);
        end
    endtask

    // Monitor: every presented write must match the oldest predicted one.
    always @(negedge clk) begin
        int e;
        if (fifo_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write t=%0t unexpected write data %h ack %b", $time, fifo_data_in, ack);
            end else begin
                e = exp_q.pop_front();
                if (fifo_data_in !== DW'(e % 256) || ack !== N'(1 << (e / 256))) begin
                    errors++;
                    $display("FAIL write t=%0t data %h ack %b want data %h ack %b",
                             $time, fifo_data_in, ack, DW'(e % 256), N'(1 << (e / 256)));
                end else begin
                    $display("write ok t=%0t producer %0d data %h", $time, e / 256, fifo_data_in);
                end
            end
        end
    end

    task automatic check_stats();
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checks++;
            if (grant_cnt[i*16 +: 16] !== 16'(m_words[i])) begin
                errors++;
                $display("FAIL stats lane %0d got %0d want %0d", i, grant_cnt[i*16 +: 16], m_words[i]);
            end
        end
`endif
    endtask

    initial begin
        rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; m_words[i] = 0; end

        cycle(1'b1, 2);
        cycle(1'b1, 2);
        cycle(1'b0, 2);
        checks++;
        if (fifo_data_in !== word_of(0, seq[0]) || gnt !== '0) begin
            errors++;
            $display("FAIL reset_lane data %h gnt %b want data %h gnt 0", fifo_data_in, gnt, word_of(0, seq[0]));
        end

        // All producers requesting, no backpressure: strict 0,1,2,3,0 rotation.
        for (int c = 0; c < 20; c++) cycle(1'b0, 1);
        check_stats();
        for (int c = 0; c < 6; c++) cycle(1'b0, 2);

        // Random traffic with backpressure, drops and occasional mid-run resets.
        for (int c = 0; c < 3000; c++) cycle($urandom_range(0, 199) == 0, 0);
        for (int c = 0; c < 8; c++) cycle(1'b0, 2);
        check_stats();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d predicted writes never seen, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
